othello_turn_ctrl: RTL and testbench

- Game-level sequencer that owns the authoritative 8x8 board, scores and turn for one Othello game.
- Arbitrates move/pass requests from two player sources (0 = black, 1 = white), launching the existing updater with a start pulse per accepted move.
- Commits the updater result only when the move flipped at least one disc, tracks consecutive passes and declares game over and winner.
- Sits between the player front-ends (keypad/AI) and the updater; drives the display board.

---
 rtl/othello_pkg.sv | 62 ++++++
 rtl/othello_result.sv | 29 ++
 rtl/othello_turn_ctrl.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_othello_turn_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/othello_pkg.sv
// Shared types and constants for the Othello game controller.
//   cell_t  : 2-bit cell code (BLACK=0, WHITE=1, EMPTY=2)
//   board_t : 8x8 packed board, indexed [row][col]
//   score_t : 6-bit disc count
//   state_t : controller state encoding
package othello_pkg;

  localparam int unsigned COORD_W = 3;
  localparam int unsigned SCORE_W = 6;
  localparam int unsigned FLIP_W  = 5;
  localparam int unsigned SUM_W   = 7;

  typedef logic [1:0] cell_t;

  localparam cell_t BLACK = 2'd0;
  localparam cell_t WHITE = 2'd1;
  localparam cell_t EMPTY = 2'd2;

  typedef cell_t [7:0][7:0]     board_t;
  typedef logic  [SCORE_W-1:0]  score_t;

  localparam logic [1:0] WIN_BLACK = 2'd0;
  localparam logic [1:0] WIN_WHITE = 2'd1;
  localparam logic [1:0] WIN_DRAW  = 2'd2;

  localparam score_t START_SCORE = 6'd2;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_WAIT_MOVE = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_WAIT_UPD  = 3'd3,
    ST_CHECK     = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

  // Every cell empty: the board shown while reset is held.
  function automatic board_t empty_board();
    board_t b;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        b[r][c] = EMPTY;
      end
    end
    return b;
  endfunction

  // Standard four-disc opening position.
  function automatic board_t start_board();
    board_t b;
    b       = empty_board();
    b[3][3] = WHITE;
    b[4][4] = WHITE;
    b[3][4] = BLACK;
    b[4][3] = BLACK;
    return b;
  endfunction

  localparam board_t EMPTY_BOARD = empty_board();
  localparam board_t START_BOARD = start_board();

endpackage

// File: rtl/othello_result.sv
// Combinational game-over / winner judge from the two committed scores.
//   i_score_black, i_score_white : disc counts
//   o_over_c   : board full (sum == 64) or one colour wiped out
//   o_winner_c : WIN_BLACK / WIN_WHITE / WIN_DRAW from the score compare
module othello_result
  import othello_pkg::*;
(
  input  score_t     i_score_black,
  input  score_t     i_score_white,
  output logic       o_over_c,
  output logic [1:0] o_winner_c
);

  logic [SUM_W-1:0] total;

  // Widen before adding so a full 64-disc board does not wrap.
  assign total = SUM_W'(i_score_black) + SUM_W'(i_score_white);

  always_comb begin
    o_over_c   = (total == SUM_W'(64)) || (i_score_black == '0) || (i_score_white == '0);
    o_winner_c = WIN_DRAW;
    if (i_score_black > i_score_white) begin
      o_winner_c = WIN_BLACK;
    end else if (i_score_white > i_score_black) begin
      o_winner_c = WIN_WHITE;
    end
  end

endmodule

// File: rtl/othello_turn_ctrl.sv
// Game-level sequencer for one Othello game: owns the committed board,
// scores and turn, arbitrates the two players and drives the move updater.
// The external updater is reset from the same i_rst source (inverted).
//
// Optional feature macro: MOVE_TIMEOUT_EN adds a per-turn move timeout
// that forces a pass and pulses o_timeout.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_new_game              restart request (level)
//   i_req_valid/pass/row/col per-player request, o_req_ready per-player accept
//   o_upd_start/color/row/col/board  launch interface to the updater
//   i_upd_board/score/flip/done      updater result
//   o_board, o_score, o_turn          committed game state
//   o_busy, o_illegal, o_game_over, o_winner  status
//   o_timeout (MOVE_TIMEOUT_EN only)  forced-pass pulse
module othello_turn_ctrl
  import othello_pkg::*;
#(
  parameter logic        FIRST_COLOR    = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_new_game,
  input  logic [1:0]              i_req_valid,
  input  logic [1:0]              i_req_pass,
  input  logic [1:0][COORD_W-1:0] i_req_row,
  input  logic [1:0][COORD_W-1:0] i_req_col,
  output logic [1:0]              o_req_ready,
  output logic                    o_upd_start,
  output logic                    o_upd_color,
  output logic [COORD_W-1:0]      o_upd_row,
  output logic [COORD_W-1:0]      o_upd_col,
  output board_t                  o_upd_board,
  input  board_t                  i_upd_board,
  input  score_t [1:0]            i_upd_score,
  input  logic [FLIP_W-1:0]       i_upd_flip,
  input  logic                    i_upd_done,
  output board_t                  o_board,
  output score_t [1:0]            o_score,
  output logic                    o_turn,
  output logic                    o_busy,
  output logic                    o_illegal,
  output logic                    o_game_over,
`ifdef MOVE_TIMEOUT_EN
  output logic                    o_timeout,
`endif
  output logic [1:0]              o_winner
);

  state_t               state_q,     state_d;
  board_t               board_q,     board_d;
  score_t [1:0]         score_q,     score_d;
  logic                 turn_q,      turn_d;
  logic [1:0]           pass_cnt_q,  pass_cnt_d;
  logic                 game_over_q, game_over_d;
  logic [1:0]           winner_q,    winner_d;
  logic                 illegal_q,   illegal_d;
  logic                 upd_start_q, upd_start_d;
  logic                 upd_color_q, upd_color_d;
  logic [COORD_W-1:0]   upd_row_q,   upd_row_d;
  logic [COORD_W-1:0]   upd_col_q,   upd_col_d;
  board_t               upd_board_q, upd_board_d;
  logic [1:0]           ready_q,     ready_d;
  logic                 busy_q,      busy_d;
  logic                 ng_pend_q,   ng_pend_d;
  logic                 do_pass;

  logic                 over_c;
  logic [1:0]           winner_c;

`ifdef MOVE_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

  logic [TMO_W-1:0]     tmo_cnt_q,   tmo_cnt_d;
  logic                 timeout_q,   timeout_d;
`else
  // The cycle budget only matters with the timeout feature; a zero budget is
  // meaningless either way, so it elaborates to an empty marker block.
  if (TIMEOUT_CYCLES == 0) begin : g_zero_timeout
  end
`endif

  // Game-over / winner judgement on the committed scores.
  othello_result u_result (
    .i_score_black (score_q[0]),
    .i_score_white (score_q[1]),
    .o_over_c      (over_c),
    .o_winner_c    (winner_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    score_d     = score_q;
    turn_d      = turn_q;
    pass_cnt_d  = pass_cnt_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    illegal_d   = 1'b0;
    upd_start_d = 1'b0;
    upd_color_d = upd_color_q;
    upd_row_d   = upd_row_q;
    upd_col_d   = upd_col_q;
    upd_board_d = upd_board_q;
    ng_pend_d   = ng_pend_q;
    do_pass     = 1'b0;
`ifdef MOVE_TIMEOUT_EN
    timeout_d   = 1'b0;
`endif

    case (state_q)
      ST_INIT: begin
        board_d     = START_BOARD;
        score_d     = {START_SCORE, START_SCORE};
        turn_d      = FIRST_COLOR;
        pass_cnt_d  = 2'd0;
        game_over_d = 1'b0;
        winner_d    = 2'd0;
        ng_pend_d   = 1'b0;
        state_d     = i_new_game ? ST_INIT : ST_WAIT_MOVE;
      end

      ST_WAIT_MOVE: begin
        // Only the player on turn is served; new game wins over any request.
        if (i_new_game) begin
          state_d = ST_INIT;
        end else if (i_req_valid[turn_q]) begin
          if (i_req_pass[turn_q]) begin
            do_pass = 1'b1;
          end else begin
            upd_color_d = turn_q;
            upd_row_d   = i_req_row[turn_q];
            upd_col_d   = i_req_col[turn_q];
            upd_board_d = board_q;
            upd_start_d = 1'b1;
            state_d     = ST_LAUNCH;
          end
        end
`ifdef MOVE_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          do_pass   = 1'b1;
          timeout_d = 1'b1;
        end
`endif
        if (do_pass) begin
          pass_cnt_d = pass_cnt_q + 2'd1;
          turn_d     = ~turn_q;
          if (pass_cnt_d == 2'd2) begin
            state_d     = ST_GAME_OVER;
            game_over_d = 1'b1;
            winner_d    = winner_c;
          end
        end
      end

      ST_LAUNCH: begin
        state_d = i_new_game ? ST_INIT : ST_WAIT_UPD;
      end

      ST_WAIT_UPD: begin
        // A restart seen while the updater runs is held until it finishes.
        ng_pend_d = ng_pend_q | i_new_game;
        if (i_upd_done) begin
          if (ng_pend_q || i_new_game) begin
            state_d = ST_INIT;
          end else begin
            if (i_upd_flip != '0) begin
              board_d    = i_upd_board;
              score_d    = i_upd_score;
              pass_cnt_d = 2'd0;
              turn_d     = ~turn_q;
            end else begin
              illegal_d = 1'b1;
            end
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (i_new_game) begin
          state_d = ST_INIT;
        end else if (over_c) begin
          state_d     = ST_GAME_OVER;
          game_over_d = 1'b1;
          winner_d    = winner_c;
        end else begin
          state_d = ST_WAIT_MOVE;
        end
      end

      ST_GAME_OVER: begin
        if (i_new_game) begin
          state_d = ST_INIT;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Ready and busy are registered from the next state so they line up with it.
    ready_d = 2'b00;
    if (state_d == ST_WAIT_MOVE) begin
      ready_d = turn_d ? 2'b10 : 2'b01;
    end
    busy_d = !((state_d == ST_WAIT_MOVE) || (state_d == ST_GAME_OVER));

`ifdef MOVE_TIMEOUT_EN
    // Restart the budget on each new turn, including after any pass.
    tmo_cnt_d = '0;
    if ((state_q == ST_WAIT_MOVE) && (state_d == ST_WAIT_MOVE) && !do_pass) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_INIT;
      board_q     <= EMPTY_BOARD;
      score_q     <= '0;
      turn_q      <= FIRST_COLOR;
      pass_cnt_q  <= 2'd0;
      game_over_q <= 1'b0;
      winner_q    <= 2'd0;
      illegal_q   <= 1'b0;
      upd_start_q <= 1'b0;
      upd_color_q <= 1'b0;
      upd_row_q   <= '0;
      upd_col_q   <= '0;
      upd_board_q <= '0;
      ready_q     <= 2'b00;
      busy_q      <= 1'b0;
      ng_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      score_q     <= score_d;
      turn_q      <= turn_d;
      pass_cnt_q  <= pass_cnt_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      illegal_q   <= illegal_d;
      upd_start_q <= upd_start_d;
      upd_color_q <= upd_color_d;
      upd_row_q   <= upd_row_d;
      upd_col_q   <= upd_col_d;
      upd_board_q <= upd_board_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      ng_pend_q   <= ng_pend_d;
    end
  end

`ifdef MOVE_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`endif

  // A restart request masks ready so a coincident request is not seen as taken.
  assign o_req_ready = ready_q & {2{~i_new_game}};
  assign o_upd_start = upd_start_q;
  assign o_upd_color = upd_color_q;
  assign o_upd_row   = upd_row_q;
  assign o_upd_col   = upd_col_q;
  assign o_upd_board = upd_board_q;
  assign o_board     = board_q;
  assign o_score     = score_q;
  assign o_turn      = turn_q;
  assign o_busy      = busy_q;
  assign o_illegal   = illegal_q;
  assign o_game_over = game_over_q;
  assign o_winner    = winner_q;

endmodule

// File: tb/tb_othello_turn_ctrl.sv
// Directed scoreboard bench for othello_turn_ctrl with a hand-driven updater stub.
module tb_othello_turn_ctrl;
  import othello_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              new_game;
  logic [1:0]        req_valid;
  logic [1:0]        req_pass;
  logic [1:0][2:0]   req_row;
  logic [1:0][2:0]   req_col;
  logic [1:0]        req_ready;
  logic              upd_start;
  logic              upd_color;
  logic [2:0]        upd_row;
  logic [2:0]        upd_col;
  board_t            upd_board_out;
  board_t            upd_board_in;
  score_t [1:0]      upd_score;
  logic [4:0]        upd_flip;
  logic              upd_done;
  board_t            board;
  score_t [1:0]      score;
  logic              turn;
  logic              busy;
  logic              illegal;
  logic              game_over;
  logic [1:0]        winner;
`ifdef MOVE_TIMEOUT_EN
  logic              timeout;
`endif

  int errors = 0;
  int checks = 0;

  string        exp_tag_q[$];
  logic [127:0] exp_val_q[$];

  board_t b_empty, b_start, b_one, b_two, b_junk;

  always #5 clk = ~clk;

  othello_turn_ctrl #(
    .FIRST_COLOR    (1'b0),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_new_game  (new_game),
    .i_req_valid (req_valid),
    .i_req_pass  (req_pass),
    .i_req_row   (req_row),
    .i_req_col   (req_col),
    .o_req_ready (req_ready),
    .o_upd_start (upd_start),
    .o_upd_color (upd_color),
    .o_upd_row   (upd_row),
    .o_upd_col   (upd_col),
    .o_upd_board (upd_board_out),
    .i_upd_board (upd_board_in),
    .i_upd_score (upd_score),
    .i_upd_flip  (upd_flip),
    .i_upd_done  (upd_done),
    .o_board     (board),
    .o_score     (score),
    .o_turn      (turn),
    .o_busy      (busy),
    .o_illegal   (illegal),
    .o_game_over (game_over),
`ifdef MOVE_TIMEOUT_EN
    .o_timeout   (timeout),
`endif
    .o_winner    (winner)
  );

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [127:0] v);
    exp_tag_q.push_back(tag);
    exp_val_q.push_back(v);
  endtask

  task automatic check_obs(input logic [127:0] obs);
    string        tag;
    logic [127:0] exp;
    checks++;
    if (exp_val_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%0h expected=<none>", obs);
    end else begin
      tag = exp_tag_q.pop_front();
      exp = exp_val_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
    end
  endtask

  function automatic board_t mk_start();
    board_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = 2'd2;
    b[3][3] = 2'd1;
    b[4][4] = 2'd1;
    b[3][4] = 2'd0;
    b[4][3] = 2'd0;
    return b;
  endfunction

  initial begin
    rst = 1'b1; new_game = 1'b0; req_valid = '0; req_pass = '0;
    req_row = '0; req_col = '0; upd_board_in = '0; upd_score = '0;
    upd_flip = '0; upd_done = 1'b0;

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b_empty[r][c] = 2'd2;
    b_start = mk_start();
    b_one = b_start;  b_one[2][3] = 2'd0; b_one[3][3] = 2'd0;
    b_two = b_one;    b_two[2][2] = 2'd1; b_two[3][3] = 2'd1;
    b_junk = '0;

    // Reset values
    step(2);
    expect_val("rst_board", 128'(b_empty));  check_obs(128'(board));
    expect_val("rst_turn", 128'(1'b0));      check_obs(128'(turn));
    expect_val("rst_ready", 128'(2'b00));    check_obs(128'(req_ready));
    expect_val("rst_score", 128'(12'd0));    check_obs(128'(score));

    // INIT loads the opening position
    rst = 1'b0;
    step();
    expect_val("init_board", 128'(b_start));        check_obs(128'(board));
    expect_val("init_score", 128'({6'd2, 6'd2}));   check_obs(128'(score));
    expect_val("init_ready", 128'(2'b01));          check_obs(128'(req_ready));
    expect_val("init_busy", 128'(1'b0));            check_obs(128'(busy));

    // Black moves (2,3) while white also requests out of turn
    req_valid = 2'b11; req_row[0] = 3'd2; req_col[0] = 3'd3;
    req_row[1] = 3'd2; req_col[1] = 3'd2;
    #1;
    expect_val("ready_black_only", 128'(2'b01));    check_obs(128'(req_ready));
    step();
    req_valid = 2'b10;
    expect_val("launch_start", 128'(1'b1));         check_obs(128'(upd_start));
    expect_val("launch_move", 128'({1'b0, 3'd2, 3'd3}));
    check_obs(128'({upd_color, upd_row, upd_col}));
    expect_val("launch_board", 128'(b_start));      check_obs(128'(upd_board_out));
    expect_val("launch_busy", 128'(1'b1));          check_obs(128'(busy));
    step();
    expect_val("start_one_cycle", 128'(1'b0));      check_obs(128'(upd_start));
    step(2);
    upd_board_in = b_one; upd_score = {6'd1, 6'd4}; upd_flip = 5'd1; upd_done = 1'b1;
    step();
    upd_done = 1'b0;
    expect_val("commit_board", 128'(b_one));        check_obs(128'(board));
    expect_val("commit_score", 128'({6'd1, 6'd4})); check_obs(128'(score));
    expect_val("commit_turn", 128'(1'b1));          check_obs(128'(turn));
    expect_val("white_held", 128'(2'b00));          check_obs(128'(req_ready));
    step();
    expect_val("ready_white", 128'(2'b10));         check_obs(128'(req_ready));

    // White's held request is now accepted
    step();
    req_valid = 2'b00;
    expect_val("white_launch", 128'({1'b1, 1'b1, 3'd2, 3'd2}));
    check_obs(128'({upd_start, upd_color, upd_row, upd_col}));
    step();
    upd_board_in = b_two; upd_score = {6'd3, 6'd3}; upd_flip = 5'd1; upd_done = 1'b1;
    step();
    upd_done = 1'b0;
    expect_val("white_commit", 128'(b_two));        check_obs(128'(board));
    expect_val("white_turn", 128'(1'b0));           check_obs(128'(turn));
    step();

    // Black plays occupied (3,3): updater reports no flips
    req_valid = 2'b01; req_row[0] = 3'd3; req_col[0] = 3'd3;
    step();
    req_valid = 2'b00;
    step();
    upd_board_in = b_junk; upd_score = {6'd7, 6'd7}; upd_flip = 5'd0; upd_done = 1'b1;
    step();
    upd_done = 1'b0;
    expect_val("illegal_pulse", 128'(1'b1));        check_obs(128'(illegal));
    expect_val("illegal_board", 128'(b_two));       check_obs(128'(board));
    expect_val("illegal_score", 128'({6'd3, 6'd3})); check_obs(128'(score));
    expect_val("illegal_turn", 128'(1'b0));         check_obs(128'(turn));
    step();
    expect_val("illegal_once", 128'(1'b0));         check_obs(128'(illegal));
    expect_val("illegal_ready", 128'(2'b01));       check_obs(128'(req_ready));

    // Stray done outside WAIT_UPD is ignored
    upd_board_in = b_junk; upd_flip = 5'd3; upd_done = 1'b1;
    step();
    upd_done = 1'b0;
    expect_val("stray_done", 128'(b_two));          check_obs(128'(board));

    // New game beats a simultaneous request
    new_game = 1'b1; req_valid = 2'b01; req_row[0] = 3'd5; req_col[0] = 3'd5;
    #1;
    expect_val("ng_ready_mask", 128'(2'b00));       check_obs(128'(req_ready));
    step();
    new_game = 1'b0; req_valid = 2'b00;
    expect_val("ng_no_start", 128'({1'b0, 1'b1}));  check_obs(128'({upd_start, busy}));
    step();
    expect_val("ng_board", 128'(b_start));          check_obs(128'(board));
    expect_val("ng_score", 128'({6'd2, 6'd2}));     check_obs(128'(score));

    // Two consecutive passes end the game as a draw
    req_valid = 2'b01; req_pass = 2'b01;
    step();
    expect_val("pass1", 128'({1'b1, 1'b0, 2'b10})); check_obs(128'({turn, game_over, req_ready}));
    req_valid = 2'b10; req_pass = 2'b10;
    step();
    req_valid = 2'b00; req_pass = 2'b00;
    expect_val("pass2_over", 128'({1'b1, 2'd2, 2'b00, 1'b0}));
    check_obs(128'({game_over, winner, req_ready, busy}));
    step(3);
    expect_val("over_hold", 128'(1'b1));            check_obs(128'(game_over));

    // Restart, then a result of 40/24 ends the game for black
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    step();
    expect_val("restart_clear", 128'({1'b0, 2'b01})); check_obs(128'({game_over, req_ready}));
    req_valid = 2'b01; req_row[0] = 3'd2; req_col[0] = 3'd3;
    step();
    req_valid = 2'b00;
    step();
    upd_board_in = b_one; upd_score = {6'd24, 6'd40}; upd_flip = 5'd4; upd_done = 1'b1;
    step();
    upd_done = 1'b0;
    expect_val("full_score", 128'({6'd24, 6'd40})); check_obs(128'(score));
    expect_val("check_not_yet", 128'(1'b0));        check_obs(128'(game_over));
    step();
    expect_val("full_over", 128'({1'b1, 2'd0}));    check_obs(128'({game_over, winner}));

    // New game during WAIT_UPD discards the updater result
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    step();
    req_valid = 2'b01; req_row[0] = 3'd2; req_col[0] = 3'd3;
    step();
    req_valid = 2'b00;
    step();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    step();
    upd_board_in = b_one; upd_score = {6'd1, 6'd4}; upd_flip = 5'd1; upd_done = 1'b1;
    step();
    upd_done = 1'b0;
    expect_val("discard_board", 128'(b_start));     check_obs(128'(board));
    expect_val("discard_score", 128'({6'd2, 6'd2})); check_obs(128'(score));
    expect_val("discard_flags", 128'({1'b0, 1'b1})); check_obs(128'({illegal, busy}));
    step();
    expect_val("discard_restart", 128'({b_start, 1'b0, 2'b01}));
    check_obs(128'({board, turn, req_ready}));

`ifdef MOVE_TIMEOUT_EN
    // Idle turn: forced pass after 16 cycles in WAIT_MOVE
    step(15);
    expect_val("tmo_not_yet", 128'({1'b0, 1'b0}));  check_obs(128'({timeout, turn}));
    step();
    expect_val("tmo_fire", 128'({1'b1, 1'b1}));     check_obs(128'({timeout, turn}));
    step();
    expect_val("tmo_pulse", 128'(1'b0));            check_obs(128'(timeout));
`endif

    if (exp_val_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed=%0d expected=0", exp_val_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
